// File: rtl/cr_su_in_arb.sv
// Schedule-update input arbiter: N_SRC one-entry source holds feeding a single
// registered output through a round-robin grant, with transfer and stall counters.
module cr_su_in_arb #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    output logic                      su_out_valid,
    output logic [DATA_W-1:0]         su_out_data,
    input  logic                      su_ready,
    output logic [31:0]               xfer_cnt,
    output logic [31:0]               stall_cnt,
    output logic [N_SRC-1:0]          src_grant
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  hold_vld_q;
    logic [N_SRC-1:0]  hold_vld_d;
    logic [DATA_W-1:0] hold_dat_q [N_SRC];
    logic              out_vld_q;
    logic              out_vld_d;
    logic [DATA_W-1:0] out_dat_q;
    logic [DATA_W-1:0] out_dat_d;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [31:0]       xfer_cnt_q;
    logic [31:0]       xfer_cnt_d;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;

    logic              out_free_s;
    logic              gnt_any_s;
    logic [PTR_W-1:0]  gnt_idx_s;
    logic [PTR_W-1:0]  srch_idx_s;
    logic [N_SRC-1:0]  grant_s;
    logic [N_SRC-1:0]  ready_s;
    logic [N_SRC-1:0]  src_xfer_s;

    assign out_free_s   = ~out_vld_q | su_ready;
    assign ready_s      = ~hold_vld_q | grant_s;
    assign src_xfer_s   = src_valid & ready_s;
    assign src_ready    = ready_s;
    assign src_grant    = grant_s;
    assign su_out_valid = out_vld_q;
    assign su_out_data  = out_dat_q;
    assign xfer_cnt     = xfer_cnt_q;
    assign stall_cnt    = stall_cnt_q;

    // Round-robin search over the full holds, starting at rr_ptr_q.
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_idx_s  = '0;
        srch_idx_s = '0;
        grant_s    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            srch_idx_s = PTR_W'((int'(rr_ptr_q) + k) % N_SRC);
            if (!gnt_any_s && hold_vld_q[srch_idx_s]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = srch_idx_s;
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
        if (out_free_s && gnt_any_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state for holds, output register, pointer and counters.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;

        // A same-cycle reload wins over the release so a source can stream at full rate.
        for (int i = 0; i < N_SRC; i++) begin
            if (src_xfer_s[i]) begin
                hold_vld_d[i] = 1'b1;
            end else if (grant_s[i]) begin
                hold_vld_d[i] = 1'b0;
            end else begin
                hold_vld_d[i] = hold_vld_q[i];
            end
        end

        if (out_free_s) begin
            if (gnt_any_s) begin
                out_vld_d = 1'b1;
                out_dat_d = hold_dat_q[gnt_idx_s];
                rr_ptr_d  = PTR_W'((int'(gnt_idx_s) + 1) % N_SRC);
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            out_vld_d = out_vld_q;
        end

        if (out_vld_q && su_ready) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end

        if (out_vld_q && !su_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= '0;
            out_vld_q   <= 1'b0;
            rr_ptr_q    <= '0;
            xfer_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            out_vld_q   <= out_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Data registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (src_xfer_s[i]) begin
                hold_dat_q[i] <= src_data[i*DATA_W +: DATA_W];
            end
        end
        out_dat_q <= out_dat_d;
    end

endmodule

// File: doc/cr_su_in_arb.md
CR_SU_IN_ARB -- requirements
Module: cr_su_in_arb

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, giving the number of upstream schedule-update sources (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the width of one schedule-update record.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port src_valid, input, N_SRC bits: per-source record valid.
REQ-006 The block SHALL have port src_data, input, N_SRC x DATA_W bits: per-source record; slice i belongs to source i.
REQ-007 The block SHALL have port src_ready, output, N_SRC bits: per-source accept; a source transfer occurs when src_valid[i] and src_ready[i] are both 1.
REQ-008 The block SHALL have port su_out_valid, output, 1 bit: a record is presented to the schedule-update core.
REQ-009 The block SHALL have port su_out_data, output, DATA_W bits: the presented record.
REQ-010 The block SHALL have port su_ready, input, 1 bit: the core accepts a record this cycle; an output transfer occurs when su_out_valid and su_ready are both 1.
REQ-011 The block SHALL have port xfer_cnt, output, 32 bits: count of output transfers, wrapping.
REQ-012 The block SHALL have port stall_cnt, output, 32 bits: count of cycles with su_out_valid=1 and su_ready=0, saturating at 0xFFFFFFFF.
REQ-013 The block SHALL have port src_grant, output, N_SRC bits: one-hot, marks the source granted in the current cycle.

Function
REQ-014 Each source SHALL own a one-entry holding register (hold_vld[i], hold_dat[i]).
REQ-015 The output register SHALL be one entry: out_vld drives su_out_valid and out_dat drives su_out_data, both directly from flops.
REQ-016 src_ready[i] SHALL equal ~hold_vld[i] | src_grant[i], combinationally, with no dependence on src_valid.
REQ-017 On a source transfer, hold_dat[i] SHALL load src_data[i] and hold_vld[i] SHALL set on the next edge.
REQ-018 out_free SHALL equal ~out_vld | su_ready.
REQ-019 A grant SHALL occur only when out_free=1 and at least one hold_vld bit is 1; otherwise src_grant SHALL be 0.
REQ-020 Arbitration SHALL be round-robin: the granted source is the first i with hold_vld[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_SRC.
REQ-021 On a grant to source g, rr_ptr SHALL become (g+1) mod N_SRC on the next edge; with no grant, rr_ptr SHALL hold.
REQ-022 On a grant, out_dat SHALL load hold_dat[g] and out_vld SHALL be 1 on the next edge.
REQ-023 If out_free=1 and there is no grant, out_vld SHALL clear on the next edge.
REQ-024 If out_free=0, out_vld and out_dat SHALL be held stable.
REQ-025 Granting g together with a source-g transfer in the same cycle SHALL reload hold g with the new record and keep hold_vld[g]=1, so the source sustains 1 record per cycle.
REQ-026 If hold_vld[g] is released by a grant and there is no new source transfer, hold_vld[g] SHALL clear.
REQ-027 Latency SHALL be 2 cycles from source transfer to su_out_valid, with an empty block and su_ready=1.
REQ-028 Total throughput SHALL be 1 output record per cycle while su_ready=1 and any hold is full.
REQ-029 No record SHALL be dropped, duplicated or reordered within a source.
REQ-030 xfer_cnt SHALL increment by 1 per output transfer and wrap from 0xFFFFFFFF to 0.
REQ-031 stall_cnt SHALL increment each stall cycle and hold at 0xFFFFFFFF.
REQ-032 Once su_out_valid=1, it SHALL NOT deassert and su_out_data SHALL NOT change until an output transfer occurs.

Reset
REQ-033 On assertion of rst_n=0, all of the following SHALL clear asynchronously to 0: hold_vld, out_vld, rr_ptr, xfer_cnt, stall_cnt.
REQ-034 During reset, src_ready SHALL be all-ones, su_out_valid 0 and src_grant 0; data registers need no reset.
REQ-035 Reset asserted mid-operation SHALL discard all held and presented records; the first post-reset grant SHALL search from source 0.

Verification
REQ-036 Single record: source 2 sends 0xA5 with su_ready=1 -> su_out_valid rises 2 cycles later with data 0xA5; xfer_cnt=1.
REQ-037 All four sources continuously valid with su_ready=1 -> grants in order 0,1,2,3,0,... with 1 record per cycle and no gaps.
REQ-038 su_ready=0 for 10 cycles with all holds full -> su_out_data stable, src_ready=0, stall_cnt=10; then su_ready=1 -> draining resumes from rr_ptr.
REQ-039 Source 1 streams back-to-back while the other sources are idle -> src_ready[1] stays 1, and records emerge in order at 1 per cycle.
REQ-040 Preload xfer_cnt near wrap (0xFFFFFFFE via 2 transfers after a forced value) -> counter wraps to 0; stall_cnt saturates and holds.
REQ-041 Assert rst_n low while holds and output are full -> su_out_valid=0 immediately, counters=0; the first grant after reset goes to source 0.
